// File: rtl/mesi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesi_bus_pkg
// Description : Shared message/response codes and FSM states for the MESI
//               snooping-bus controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mesi_bus_pkg;

    localparam logic [1:0] MSG_NONE    = 2'b00;
    localparam logic [1:0] MSG_RD_MISS = 2'b01;
    localparam logic [1:0] MSG_WR_MISS = 2'b10;
    localparam logic [1:0] MSG_INV     = 2'b11;

    localparam logic [1:0] RSP_MISS  = 2'b00;
    localparam logic [1:0] RSP_CLEAN = 2'b01;
    localparam logic [1:0] RSP_DIRTY = 2'b10;
    localparam logic [1:0] RSP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BCAST  = 3'd1,
        ST_SNOOP  = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mesi_bus_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first unmasked requester at
//               or after the pointer, wrapping to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mesi_bus_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int IDX_W      = $clog2(NUM_CACHES)
) (
    input  logic [NUM_CACHES-1:0] req,
    input  logic [NUM_CACHES-1:0] mask,
    input  logic [IDX_W-1:0]      ptr,
    output logic [NUM_CACHES-1:0] grant,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    logic [NUM_CACHES-1:0] w_cand;

    always_comb begin
        w_cand = req & ~mask;
        grant  = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_CACHES) j = j - NUM_CACHES;
            if (!valid && w_cand[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mesi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mesi_bus_ctrl
// Description : Snooping-bus controller: arbitrates MESI bus requests,
//               broadcasts, gathers snoop replies, sequences memory/write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_bus_ctrl
    import mesi_bus_pkg::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                         clock,
    input  logic                         Reset,
    input  logic [2*NUM_CACHES-1:0]      req_msg,
    input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
    input  logic [2*NUM_CACHES-1:0]      snoop_resp,
    output logic [1:0]                   bus_msg,
    output logic [ADDR_W-1:0]            bus_addr,
    output logic [NUM_CACHES-1:0]        bus_src,
    output logic                         bus_valid,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_ready,
    output logic [NUM_CACHES-1:0]        done,
    output logic                         shared_out,
    output logic                         busy,
    output logic                         err
);

    localparam int c_IDX_W = $clog2(NUM_CACHES);

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [1:0]            r_msg;
    logic [ADDR_W-1:0]     r_addr;
    logic [NUM_CACHES-1:0] r_src;
    logic [NUM_CACHES-1:0] r_mask;
    logic                  r_shared;
    logic [1:0]            r_bus_msg;
    logic                  r_bus_valid;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [NUM_CACHES-1:0] r_done;
    logic                  r_shared_out;
    logic                  r_busy;
    logic                  r_err;

    logic [NUM_CACHES-1:0] w_req_vec;
    logic [NUM_CACHES-1:0] w_gnt;
    logic [c_IDX_W-1:0]    w_gnt_idx;
    logic                  w_gnt_valid;
    logic [1:0]            w_sel_msg;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic                  w_shared;
    logic                  w_rsvd;
    logic [3:0]            w_dirty_cnt;
    logic [c_IDX_W-1:0]    w_ptr_next;

    generate
        for (genvar g = 0; g < NUM_CACHES; g++) begin : g_req
            assign w_req_vec[g] = |req_msg[2*g +: 2];
        end
    endgenerate

    rr_arbiter #(
        .NUM_CACHES (NUM_CACHES),
        .IDX_W      (c_IDX_W)
    ) u_arb (
        .req   (w_req_vec),
        .mask  (r_mask),
        .ptr   (r_ptr),
        .grant (w_gnt),
        .idx   (w_gnt_idx),
        .valid (w_gnt_valid)
    );

    always_comb begin
        w_sel_msg  = MSG_NONE;
        w_sel_addr = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (w_gnt[i]) begin
                w_sel_msg  = req_msg[2*i +: 2];
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // The requester's own snoop reply is ignored.
    always_comb begin
        w_shared    = 1'b0;
        w_rsvd      = 1'b0;
        w_dirty_cnt = 4'd0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (!r_src[i]) begin
                case (snoop_resp[2*i +: 2])
                    RSP_CLEAN: w_shared = 1'b1;
                    RSP_DIRTY: begin
                        w_shared    = 1'b1;
                        w_dirty_cnt = w_dirty_cnt + 4'd1;
                    end
                    RSP_RSVD:  w_rsvd = 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign w_ptr_next = (r_idx == c_IDX_W'(NUM_CACHES - 1)) ? '0 : r_idx + c_IDX_W'(1);

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_ptr        <= '0;
            r_msg        <= MSG_NONE;
            r_addr       <= '0;
            r_src        <= '0;
            r_mask       <= '0;
            r_shared     <= 1'b0;
            r_bus_msg    <= MSG_NONE;
            r_bus_valid  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_done       <= '0;
            r_shared_out <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_bus_valid <= 1'b0;
            r_bus_msg   <= MSG_NONE;
            r_done      <= '0;
            case (r_state)
                ST_IDLE: begin
                    // Last-served mask only lives for the first IDLE cycle.
                    r_mask <= '0;
                    if (w_gnt_valid) begin
                        r_idx       <= w_gnt_idx;
                        r_src       <= w_gnt;
                        r_msg       <= w_sel_msg;
                        r_addr      <= w_sel_addr;
                        r_bus_valid <= 1'b1;
                        r_bus_msg   <= w_sel_msg;
                        r_busy      <= 1'b1;
                        r_state     <= ST_BCAST;
                    end
                end
                ST_BCAST: r_state <= ST_SNOOP;
                ST_SNOOP: begin
                    r_shared <= w_shared;
                    if (w_dirty_cnt > 4'd1 || w_rsvd) r_err <= 1'b1;
                    if (r_msg == MSG_INV) begin
                        r_done       <= r_src;
                        r_shared_out <= w_shared;
                        r_state      <= ST_DONE;
                    end else if (w_dirty_cnt != 4'd0) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_state   <= ST_WB;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_MEM_RD;
                    end
                end
                ST_MEM_RD, ST_WB: begin
                    if (mem_ready) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_done       <= r_src;
                        r_shared_out <= r_shared;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= w_ptr_next;
                    r_mask  <= r_src;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_msg    = r_bus_msg;
    assign bus_addr   = r_addr;
    assign bus_src    = r_src;
    assign bus_valid  = r_bus_valid;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign done       = r_done;
    assign shared_out = r_shared_out;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mesi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesi_bus_ctrl
// Description : Directed self-checking bench for mesi_bus_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_bus_ctrl;

    localparam int N = 4;
    localparam int AW = 8;

    logic            clock = 1'b0;
    logic            Reset;
    logic [2*N-1:0]  req_msg;
    logic [AW*N-1:0] req_addr;
    logic [2*N-1:0]  snoop_resp;
    logic [1:0]      bus_msg;
    logic [AW-1:0]   bus_addr;
    logic [N-1:0]    bus_src;
    logic            bus_valid;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic [N-1:0]    done;
    logic            shared_out;
    logic            busy;
    logic            err;

    mesi_bus_ctrl #(.NUM_CACHES(N), .ADDR_W(AW)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .req_msg    (req_msg),
        .req_addr   (req_addr),
        .snoop_resp (snoop_resp),
        .bus_msg    (bus_msg),
        .bus_addr   (bus_addr),
        .bus_src    (bus_src),
        .bus_valid  (bus_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .done       (done),
        .shared_out (shared_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    int cyc, bv_cnt, rd_cnt, wb_cnt, dn_cnt, dn_cyc, mem_wait, mem_delay;
    logic [1:0]    bv_msg;
    logic [AW-1:0] bv_addr, ma;
    logic [N-1:0]  bv_src, dn;
    logic          dn_sh;
    bit            auto_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One clock; observe outputs 1 time unit after the edge and play memory.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (bus_valid) begin
            bv_cnt++;
            bv_msg = bus_msg; bv_addr = bus_addr; bv_src = bus_src;
        end
        if (mem_req) begin
            if (mem_we) wb_cnt++;
            else rd_cnt++;
            ma = mem_addr;
        end
        if (done != '0) begin
            dn = done; dn_sh = shared_out; dn_cyc = cyc; dn_cnt++;
            if (auto_drop)
                for (int i = 0; i < N; i++)
                    if (done[i]) req_msg[2*i +: 2] = 2'b00;
        end
        mem_ready = mem_req && (mem_wait >= mem_delay);
        mem_wait  = mem_req ? mem_wait + 1 : 0;
    endtask

    task automatic clr();
        cyc = 0; bv_cnt = 0; rd_cnt = 0; wb_cnt = 0; dn_cnt = 0; dn_cyc = -1;
        mem_wait = 0; dn = '0; dn_sh = 1'b0; bv_msg = '0; bv_addr = '0; bv_src = '0; ma = '0;
    endtask

    task automatic set_req(input int c, input logic [1:0] m, input logic [AW-1:0] a);
        req_msg[2*c +: 2]   = m;
        req_addr[AW*c +: AW] = a;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k;
        k = 0;
        while (dn_cnt == 0 && k < max) begin
            tick();
            k++;
        end
        check({tag, "_seen"}, 32'(dn_cnt != 0), 32'd1);
    endtask

    initial begin
        Reset = 1'b1; req_msg = '0; req_addr = '0; snoop_resp = '0; mem_ready = 1'b0;
        auto_drop = 1'b1; mem_delay = 0;
        clr();
        repeat (3) tick();
        check("rst_bus_valid", 32'(bus_valid), 0);
        check("rst_bus_msg", 32'(bus_msg), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy_err", {busy, err, shared_out}, 0);
        Reset = 1'b0;

        // Read miss by cache 2; requester's own dirty reply must be ignored.
        clr(); mem_delay = 2;
        set_req(2, 2'b01, 8'h3C); snoop_resp = 8'b00_10_00_00;
        tick();
        check("t1_busy", 32'(busy), 1);
        wait_done("t1", 20);
        check("t1_bv_cnt", bv_cnt, 1);
        check("t1_bus_msg", 32'(bv_msg), 1);
        check("t1_bus_src", 32'(bv_src), 32'b0100);
        check("t1_bus_addr", 32'(bv_addr), 32'h3C);
        check("t1_rd_cyc", rd_cnt, 3);
        check("t1_wb_cyc", wb_cnt, 0);
        check("t1_done", 32'(dn), 32'b0100);
        check("t1_done_cyc", dn_cyc, 6);
        check("t1_shared", 32'(dn_sh), 0);
        tick();
        check("t1_idle_busy", 32'(busy), 0);

        // Write miss by cache 0, cache 3 holds it dirty.
        clr(); mem_delay = 0;
        set_req(0, 2'b10, 8'h10); snoop_resp = 8'b10_00_00_00;
        wait_done("t2", 20);
        check("t2_bus_msg", 32'(bv_msg), 2);
        check("t2_wb_cyc", wb_cnt, 1);
        check("t2_rd_cyc", rd_cnt, 0);
        check("t2_mem_addr", 32'(ma), 32'h10);
        check("t2_done", 32'(dn), 32'b0001);
        check("t2_done_cyc", dn_cyc, 4);
        check("t2_shared", 32'(dn_sh), 1);
        tick();

        // Invalidate by cache 1, caches 0 and 2 clean sharers.
        clr();
        set_req(1, 2'b11, 8'h55); snoop_resp = 8'b00_01_00_01;
        wait_done("t3", 20);
        check("t3_bus_msg", 32'(bv_msg), 3);
        check("t3_mem", rd_cnt + wb_cnt, 0);
        check("t3_done", 32'(dn), 32'b0010);
        check("t3_done_cyc", dn_cyc, 3);
        check("t3_shared", 32'(dn_sh), 1);
        tick();
        check("t3_err", 32'(err), 0);

        // Round-robin among continuously requesting caches 0, 1, 3.
        Reset = 1'b1; tick(); Reset = 1'b0;
        auto_drop = 1'b0; snoop_resp = '0;
        set_req(0, 2'b01, 8'h01); set_req(1, 2'b01, 8'h02); set_req(3, 2'b01, 8'h04);
        begin
            logic [N-1:0] exp_ord [4];
            exp_ord[0] = 4'b0001; exp_ord[1] = 4'b0010; exp_ord[2] = 4'b1000; exp_ord[3] = 4'b0001;
            for (int t = 0; t < 4; t++) begin
                clr();
                wait_done($sformatf("rr%0d", t), 20);
                check($sformatf("rr%0d_done", t), 32'(dn), 32'(exp_ord[t]));
                check($sformatf("rr%0d_bv", t), bv_cnt, 1);
            end
        end
        req_msg = '0; auto_drop = 1'b1;
        tick(); tick();

        // Two dirty owners: error is sticky, single write-back.
        clr();
        set_req(2, 2'b01, 8'h77); snoop_resp = 8'b00_00_10_10;
        wait_done("t5", 20);
        check("t5_err", 32'(err), 1);
        check("t5_wb_cyc", wb_cnt, 1);
        check("t5_rd_cyc", rd_cnt, 0);
        check("t5_done", 32'(dn), 32'b0100);
        repeat (3) tick();
        clr(); snoop_resp = '0;
        set_req(3, 2'b01, 8'h20);
        wait_done("t5b", 20);
        check("t5_err_sticky", 32'(err), 1);
        tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("t5_err_clr", 32'(err), 0);

        // Reserved reply sets err.
        clr(); snoop_resp = 8'b00_00_11_00;
        set_req(0, 2'b01, 8'h30);
        wait_done("t6", 20);
        check("t6_err", 32'(err), 1);
        check("t6_shared", 32'(dn_sh), 0);
        tick();
        Reset = 1'b1; tick(); Reset = 1'b0;

        // Move pointer to 2, then reset during MEM_RD.
        clr(); snoop_resp = '0;
        set_req(1, 2'b01, 8'h40);
        wait_done("t7a", 20);
        tick();
        clr(); mem_delay = 100;
        set_req(1, 2'b01, 8'h41);
        begin
            int k;
            k = 0;
            while (!mem_req && k < 20) begin tick(); k++; end
        end
        check("t7_mem_req_up", 32'(mem_req), 1);
        Reset = 1'b1; tick();
        check("t7_rst_mem_req", 32'(mem_req), 0);
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_done", 32'(done), 0);
        Reset = 1'b0; req_msg = '0; mem_delay = 0;
        clr();
        set_req(0, 2'b01, 8'h50); set_req(3, 2'b01, 8'h51);
        wait_done("t7b", 20);
        check("t7_ptr0_done", 32'(dn), 32'b0001);
        check("t7_done_cyc", dn_cyc, 4);
        tick();
        clr();
        wait_done("t7c", 20);
        check("t7_next_done", 32'(dn), 32'b1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mesi_bus_ctrl.md
Name: mesi_bus_ctrl

Overview:
- Shared snooping-bus controller: the bus/memory end of the MESI protocol driven by the per-cache-block MESI controllers.
- Collects bus requests (read miss, write miss, invalidate) from NUM_CACHES cache controllers and arbitrates round-robin.
- Broadcasts the winning request to all snoopers and gathers their snoop responses.
- Sequences the memory access or owner write-back, then returns completion and the shared indication (the requester's CPU shared bit).

Parameters:
NUM_CACHES, 4, number of cache controllers on the bus (2..8)
ADDR_W, 8, block address width

Ports:
clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
req_msg  in  2*NUM_CACHES  per-cache bus request: 00 none, 01 read miss, 10 write miss, 11 invalidate; held until done
req_addr  in  ADDR_W*NUM_CACHES  per-cache block address, valid while req_msg != 00
snoop_resp  in  2*NUM_CACHES  per-cache snoop reply sampled in SNOOP: 00 miss, 01 hit clean, 10 hit dirty (write-back + abort), 11 reserved (treated as 00, sets err)
bus_msg  out  2  broadcast message, non-zero only in BCAST
bus_addr  out  ADDR_W  broadcast address, valid with bus_valid
bus_src  out  NUM_CACHES  one-hot requester, valid with bus_valid; snoopers matching bus_src ignore the broadcast
bus_valid  out  1  high for exactly the BCAST cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = write-back, 0 = block read
mem_addr  out  ADDR_W  latched request address
mem_ready  in  1  memory completes the current access this cycle
done  out  NUM_CACHES  one-hot, one-cycle completion pulse to the requester
shared_out  out  1  another cache held the block; valid with done, held until the next done
busy  out  1  FSM not in IDLE
err  out  1  sticky protocol error (multiple dirty owners or reserved response); cleared only by Reset

Behaviour:
- Reset (synchronous, sampled on the clock edge):
  - All outputs 0; FSM to IDLE; round-robin pointer 0; last-served mask cleared; err cleared.
  - Applies mid-transaction: an outstanding mem_req is dropped without waiting for mem_ready.
- States: IDLE, BCAST, SNOOP, MEM_RD, WB, DONE.
- IDLE:
  - Candidates are caches with req_msg != 00, excluding the cache served in the immediately preceding DONE (mask valid for this one cycle only).
  - Round-robin pick: first candidate at or after the pointer, wrapping from NUM_CACHES-1 to 0.
  - Latch index, message and address; go to BCAST. With no candidate, stay in IDLE.
- BCAST: bus_valid=1, drive bus_msg/bus_addr/bus_src from the latches; go to SNOOP.
- SNOOP:
  - Sample snoop_resp of every cache except the requester.
  - shared flag = any response in {01, 10}.
  - Dirty count = number of responses equal to 10; a count >1 sets err.
  - Next state: msg=11 goes to DONE (no memory access); dirty count >=1 goes to WB; otherwise MEM_RD.
- WB: mem_req=1, mem_we=1. On mem_ready go to DONE. The owner supplies the data and the memory read is aborted, so no MEM_RD follows.
- MEM_RD: mem_req=1, mem_we=0. On mem_ready go to DONE.
- mem_ready seen outside MEM_RD/WB is ignored.
- DONE:
  - done[idx]=1 for one cycle; shared_out registered.
  - Pointer = idx+1 modulo NUM_CACHES; go to IDLE.
- Requests withdrawn (req_msg to 00) after the grant do not abort the transaction.
- Latency from request seen in IDLE (cycle 0):
  - Invalidate: done in cycle 3.
  - Memory access with mem_ready asserted the first cycle: done in cycle 4.
  - Each extra wait cycle adds 1.
- Requests arriving while busy wait; there is no queueing beyond the held req_msg.

Decomposition:
- Package mesi_bus_pkg holds:
  - Message codes: MSG_NONE, MSG_RD_MISS, MSG_WR_MISS, MSG_INV.
  - Snoop response codes: RSP_MISS, RSP_CLEAN, RSP_DIRTY.
  - FSM state enumeration.
- One sub-module, rr_arbiter: parameterised NUM_CACHES; inputs request vector, mask and pointer; outputs one-hot grant and binary index; purely combinational.

Test Plan:
- Cache 2 issues read miss at addr 0x3C, all snoops 00, mem_ready 2 cycles after mem_req → bus_valid once with bus_msg=01 and bus_src=0100; mem_we=0; done=0100, shared_out=0.
- Cache 0 issues write miss at 0x10, cache 3 responds 10 → WB with mem_we=1 at addr 0x10, no MEM_RD; done=0001, shared_out=1.
- Cache 1 issues invalidate, caches 0 and 2 respond 01 → no mem_req; done=0010 in cycle 3; shared_out=1.
- Caches 0, 1 and 3 all hold read misses continuously → grants in order 0, 1, 3, 0, with no back-to-back regrant to the same cache.
- Two caches respond 10 to one read miss → err=1 and stays 1, single WB, done still pulsed; err clears only on Reset.
- Reset asserted during MEM_RD with mem_req=1 → the next cycle shows IDLE, mem_req=0, busy=0, done=0, and the pointer at 0.
